// File: rtl/dram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_arb_pkg : shared types for the two-master data-RAM arbiter             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   typedef logic master_id_t;

   localparam master_id_t M_CPU  = 1'b0;
   localparam master_id_t M_LOAD = 1'b1;

   function automatic arb_state_t lock_state(input master_id_t m);
      return (m == M_LOAD) ? LOCK1 : LOCK0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_arbiter : round-robin, lockable two-master front end for the data RAM  |
// | Optional statistics counters enabled by defining DRAM_ARB_STATS_EN.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   output logic              m0_err,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              m1_err,
   output logic [ADDR_W-1:0] data_address,
   output logic              data_read,
   output logic              data_write,
   output logic [DATA_W-1:0] data_writedata,
`ifdef DRAM_ARB_STATS_EN
   output logic [31:0]       stat_grant0,
   output logic [31:0]       stat_grant1,
   output logic [31:0]       stat_conflict,
`endif
   input  logic [DATA_W-1:0] data_readdata
);

   localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH_WORDS);

   arb_state_t        state_q;
   master_id_t        rr_last_q;
   logic [1:0]        w_read, w_write, w_lock, w_req, w_gnt, w_illegal;
   logic [ADDR_W-1:0] w_addr  [2];
   logic [DATA_W-1:0] w_wdata [2];
   master_id_t        w_win;
   logic              w_any, w_conflict;

   assign w_read     = {m1_read,  m0_read};
   assign w_write    = {m1_write, m0_write};
   assign w_lock     = {m1_lock,  m0_lock};
   assign w_addr[0]  = m0_address;
   assign w_addr[1]  = m1_address;
   assign w_wdata[0] = m0_writedata;
   assign w_wdata[1] = m1_writedata;
   assign w_req      = w_read | w_write;
   assign w_conflict = &w_req;

   // Grant depends only on registered state, so a lock drop frees the bus one cycle later.
   always_comb begin
      w_gnt = 2'b00;
      if (rst_n) begin
         case (state_q)
            LOCK0:   w_gnt = {1'b0, w_req[0]};
            LOCK1:   w_gnt = {w_req[1], 1'b0};
            default: w_gnt = w_conflict ? ((rr_last_q == M_LOAD) ? 2'b01 : 2'b10) : w_req;
         endcase
      end
   end

   assign w_any = |w_gnt;
   assign w_win = w_gnt[1];

   for (genvar g = 0; g < 2; g++) begin : g_illegal
      assign w_illegal[g] = (w_read[g] & w_write[g]) | ((w_addr[g] >> 2) >= c_DEPTH);
   end

   assign data_address   = w_addr[w_win];
   assign data_writedata = w_wdata[w_win];
   assign data_read      = w_any & w_read[w_win]  & ~w_illegal[w_win];
   assign data_write     = w_any & w_write[w_win] & ~w_illegal[w_win];

   assign m0_waitrequest = ~w_gnt[0];
   assign m1_waitrequest = ~w_gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= M_LOAD;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_conflict) rr_last_q <= w_win;
               if (w_any && w_lock[w_win]) state_q <= lock_state(w_win);
            end
            LOCK0:   if (!w_lock[M_CPU])  state_q <= IDLE;
            LOCK1:   if (!w_lock[M_LOAD]) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_resp
      logic [DATA_W-1:0] rdata_q;
      logic              rvalid_q;
      logic              err_q;
      logic              w_rd_ok;

      assign w_rd_ok = w_gnt[g] & w_read[g] & ~w_illegal[g];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            rvalid_q <= w_rd_ok;
            err_q    <= w_gnt[g] & w_illegal[g];
            if (w_rd_ok) rdata_q <= data_readdata;
         end
      end
   end

   assign m0_readdata      = g_resp[0].rdata_q;
   assign m0_readdatavalid = g_resp[0].rvalid_q;
   assign m0_err           = g_resp[0].err_q;
   assign m1_readdata      = g_resp[1].rdata_q;
   assign m1_readdatavalid = g_resp[1].rvalid_q;
   assign m1_err           = g_resp[1].err_q;

`ifdef DRAM_ARB_STATS_EN
   logic [31:0] grant0_q, grant1_q, conflict_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant0_q   <= '0;
         grant1_q   <= '0;
         conflict_q <= '0;
      end else begin
         if (w_gnt[0])   grant0_q   <= grant0_q + 32'd1;
         if (w_gnt[1])   grant1_q   <= grant1_q + 32'd1;
         if (w_conflict) conflict_q <= conflict_q + 32'd1;
      end
   end

   assign stat_grant0   = grant0_q;
   assign stat_grant1   = grant1_q;
   assign stat_conflict = conflict_q;
`endif

endmodule
`default_nettype wire
